// File: rtl/sda_kernel_ctrl_hs_regs.sv
// ap_ctrl_hs kernel control register bank with go/done four-phase handshake sequencer.
// Optional auto-restart support is enabled by defining SDA_KERNEL_AUTO_RESTART_EN.
module sda_kernel_ctrl_hs_regs #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              reg_req,
    output logic              reg_ack,
    input  logic              reg_write_en,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [31:0]       reg_wdata,
    input  logic [3:0]        reg_wstrb,
    output logic [31:0]       reg_rdata,
    output logic              go_0r,
    input  logic              go_0a,
    input  logic              done_0r,
    output logic              done_0a,
    output logic              interrupt
);

    localparam int unsigned WordW = ADDR_W - 2;

    typedef enum logic [2:0] {
        StIdle,
        StGoReq,
        StGoRel,
        StRun,
        StDoneAck
    } state_e;

    state_e     state_q;
    logic       ap_start_q;
    logic       ap_done_q;
    logic       ap_ready_q;
    logic       gie_q;
    logic [1:0] ier_q;
    logic [1:0] isr_q;
    logic [1:0] isr_d;
    logic       auto_restart;

    logic [WordW-1:0] word;
    logic             access;
    logic             wr;
    logic             rd;
    logic             sel_ctrl;
    logic             sel_gie;
    logic             sel_ier;
    logic             sel_isr;
    logic             is_idle;
    logic             go_evt;
    logic             done_evt;
    logic [31:0]      rd_mux;

    assign word     = reg_addr[ADDR_W-1:2];
    // The selector holds reg_req through the ack cycle, so only the first high cycle is an access.
    assign access   = reg_req & ~reg_ack;
    assign wr       = access & reg_write_en & reg_wstrb[0];
    assign rd       = access & ~reg_write_en;
    assign sel_ctrl = (word == WordW'(0));
    assign sel_gie  = (word == WordW'(1));
    assign sel_ier  = (word == WordW'(2));
    assign sel_isr  = (word == WordW'(3));
    assign is_idle  = (state_q == StIdle);
    assign go_evt   = (state_q == StGoReq) & go_0a;
    assign done_evt = (state_q == StDoneAck) & ~done_0r;

`ifdef SDA_KERNEL_AUTO_RESTART_EN
    logic auto_restart_q;
    assign auto_restart = auto_restart_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            auto_restart_q <= 1'b0;
        end else if (wr && sel_ctrl) begin
            auto_restart_q <= reg_wdata[7];
        end
    end
`else
    assign auto_restart = 1'b0;
`endif

    always_comb begin
        rd_mux = 32'h0;
        if (sel_ctrl) begin
            rd_mux = {24'h0, auto_restart, 3'b000, ap_ready_q, is_idle, ap_done_q, ap_start_q};
        end else if (sel_gie) begin
            rd_mux = {31'h0, gie_q};
        end else if (sel_ier) begin
            rd_mux = {30'h0, ier_q};
        end else if (sel_isr) begin
            rd_mux = {30'h0, isr_q};
        end
    end

    // Hardware sets are ORed in after the toggle so they win a same-cycle collision.
    always_comb begin
        isr_d = isr_q;
        if (wr && sel_isr) begin
            isr_d = isr_q ^ reg_wdata[1:0];
        end
        isr_d = isr_d | {go_evt & ier_q[1], done_evt & ier_q[0]};
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            reg_ack    <= 1'b0;
            reg_rdata  <= 32'h0;
            ap_start_q <= 1'b0;
            ap_done_q  <= 1'b0;
            ap_ready_q <= 1'b0;
            gie_q      <= 1'b0;
            ier_q      <= 2'b00;
            isr_q      <= 2'b00;
            interrupt  <= 1'b0;
        end else begin
            reg_ack   <= access;
            reg_rdata <= rd ? rd_mux : 32'h0;
            isr_q     <= isr_d;
            interrupt <= gie_q & (|isr_q);

            // Start writes and the two hardware updates occur in disjoint states.
            if (wr && sel_ctrl && is_idle) begin
                ap_start_q <= reg_wdata[0];
            end else if (go_evt) begin
                ap_start_q <= 1'b0;
            end else if (done_evt && auto_restart) begin
                ap_start_q <= 1'b1;
            end

            if (done_evt) begin
                ap_done_q <= 1'b1;
            end else if (rd && sel_ctrl) begin
                ap_done_q <= 1'b0;
            end

            if (go_evt) begin
                ap_ready_q <= 1'b1;
            end else if (rd && sel_ctrl) begin
                ap_ready_q <= 1'b0;
            end

            if (wr && sel_gie) begin
                gie_q <= reg_wdata[0];
            end
            if (wr && sel_ier) begin
                ier_q <= reg_wdata[1:0];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= StIdle;
            go_0r   <= 1'b0;
            done_0a <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ap_start_q) begin
                        go_0r   <= 1'b1;
                        state_q <= StGoReq;
                    end
                end
                StGoReq: begin
                    if (go_0a) begin
                        go_0r   <= 1'b0;
                        state_q <= StGoRel;
                    end
                end
                StGoRel: begin
                    if (!go_0a) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (done_0r) begin
                        done_0a <= 1'b1;
                        state_q <= StDoneAck;
                    end
                end
                StDoneAck: begin
                    if (!done_0r) begin
                        done_0a <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    go_0r   <= 1'b0;
                    done_0a <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sda_kernel_ctrl_hs_regs.sv
// Directed self-checking bench for sda_kernel_ctrl_hs_regs; define SDA_KERNEL_AUTO_RESTART_EN
// to also exercise the auto-restart loop.
module tb_sda_kernel_ctrl_hs_regs;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        reg_req;
    logic        reg_ack;
    logic        reg_write_en;
    logic [5:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic [31:0] reg_rdata;
    logic        go_0r;
    logic        go_0a;
    logic        done_0r;
    logic        done_0a;
    logic        interrupt;

    int checks;
    int failures;
    int go_count;
    int go_base;
    logic go_at_ack;

    sda_kernel_ctrl_hs_regs #(
        .ADDR_W(6)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .reg_req     (reg_req),
        .reg_ack     (reg_ack),
        .reg_write_en(reg_write_en),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_wstrb   (reg_wstrb),
        .reg_rdata   (reg_rdata),
        .go_0r       (go_0r),
        .go_0a       (go_0a),
        .done_0r     (done_0r),
        .done_0a     (done_0a),
        .interrupt   (interrupt)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial go_count = 0;
    always @(posedge go_0r) go_count <= go_count + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with reg_req low for one full cycle.
    task automatic reg_access(input logic wr, input logic [5:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata);
        reg_req      = 1'b1;
        reg_write_en = wr;
        reg_addr     = addr;
        reg_wdata    = wdata;
        reg_wstrb    = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge ap_clk);
            if (reg_ack) break;
        end
        check_eq("reg_ack", {31'h0, reg_ack}, 32'h1);
        rdata        = reg_rdata;
        go_at_ack    = go_0r;
        reg_req      = 1'b0;
        reg_write_en = 1'b0;
        @(negedge ap_clk);
    endtask

    task automatic reg_write(input logic [5:0] addr, input logic [31:0] wdata);
        logic [31:0] unused;
        reg_access(1'b1, addr, wdata, unused);
    endtask

    task automatic reg_read_check(input string tag, input logic [5:0] addr,
                                  input logic [31:0] exp);
        logic [31:0] rdata;
        reg_access(1'b0, addr, 32'h0, rdata);
        check_eq(tag, rdata, exp);
    endtask

    // Action side of the go handshake; returns at a negedge with the FSM in RUN.
    task automatic do_go(input int delay);
        for (int i = 0; i < 20; i++) begin
            if (go_0r) break;
            @(negedge ap_clk);
        end
        check_eq("go_0r_rise", {31'h0, go_0r}, 32'h1);
        repeat (delay) @(negedge ap_clk);
        go_0a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge ap_clk);
            if (!go_0r) break;
        end
        check_eq("go_0r_fall", {31'h0, go_0r}, 32'h0);
        go_0a = 1'b0;
        @(negedge ap_clk);
    endtask

    // Action side of the done handshake; returns at the negedge where done_0a is first seen low.
    task automatic do_done(input int delay);
        repeat (delay) @(negedge ap_clk);
        done_0r = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge ap_clk);
            if (done_0a) break;
        end
        check_eq("done_0a_rise", {31'h0, done_0a}, 32'h1);
        done_0r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge ap_clk);
            if (!done_0a) break;
        end
        check_eq("done_0a_fall", {31'h0, done_0a}, 32'h0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        go_at_ack    = 1'b0;
        ap_rst_n     = 1'b0;
        reg_req      = 1'b0;
        reg_write_en = 1'b0;
        reg_addr     = '0;
        reg_wdata    = '0;
        reg_wstrb    = '0;
        go_0a        = 1'b0;
        done_0r      = 1'b0;
        repeat (2) @(negedge ap_clk);
        check_eq("rst_go_0r", {31'h0, go_0r}, 32'h0);
        check_eq("rst_done_0a", {31'h0, done_0a}, 32'h0);
        check_eq("rst_irq", {31'h0, interrupt}, 32'h0);
        check_eq("rst_ack", {31'h0, reg_ack}, 32'h0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        reg_read_check("rst_ctrl", 6'h00, 32'h4);
        reg_read_check("rst_isr", 6'h0C, 32'h0);

        // Single run with interrupts disabled.
        go_base = go_count;
        reg_write(6'h00, 32'h1);
        check_eq("go_at_ack", {31'h0, go_at_ack}, 32'h0);
        check_eq("go_after_ack", {31'h0, go_0r}, 32'h1);
        do_go(3);
        do_done(10);
        reg_read_check("ctrl_done", 6'h00, 32'hE);
        reg_read_check("ctrl_cor", 6'h00, 32'h4);
        reg_read_check("isr_masked", 6'h0C, 32'h0);
        check_eq("go_count_1", go_count - go_base, 32'h1);

        // Interrupt path, ISR toggle, unmapped address.
        reg_write(6'h04, 32'h1);
        reg_write(6'h08, 32'h1);
        reg_read_check("gie_rd", 6'h04, 32'h1);
        reg_read_check("ier_rd", 6'h08, 32'h1);
        reg_write(6'h00, 32'h1);
        do_go(1);
        do_done(2);
        check_eq("irq_lat0", {31'h0, interrupt}, 32'h0);
        @(negedge ap_clk);
        check_eq("irq_lat1", {31'h0, interrupt}, 32'h1);
        reg_read_check("isr_done", 6'h0C, 32'h1);
        reg_write(6'h0C, 32'h1);
        check_eq("irq_clr", {31'h0, interrupt}, 32'h0);
        reg_read_check("isr_clr", 6'h0C, 32'h0);
        reg_write(6'h0C, 32'h2);
        reg_read_check("isr_tog1", 6'h0C, 32'h2);
        reg_write(6'h0C, 32'h2);
        reg_read_check("isr_tog0", 6'h0C, 32'h0);
        reg_write(6'h10, 32'hFF);
        reg_read_check("unmapped", 6'h10, 32'h0);

        // Start write during RUN is ignored.
        go_base = go_count;
        reg_write(6'h00, 32'h1);
        do_go(2);
        reg_write(6'h00, 32'h1);
        reg_read_check("ctrl_run", 6'h00, 32'hA);
        do_done(1);
        repeat (4) @(negedge ap_clk);
        check_eq("no_rego", {31'h0, go_0r}, 32'h0);
        check_eq("go_count_run", go_count - go_base, 32'h1);
        reg_read_check("ctrl_after_run", 6'h00, 32'h6);
        reg_read_check("ctrl_idle", 6'h00, 32'h4);

        // Asynchronous reset while done_0a is held.
        reg_write(6'h00, 32'h1);
        do_go(1);
        done_0r = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge ap_clk);
            if (done_0a) break;
        end
        check_eq("pre_rst_done_0a", {31'h0, done_0a}, 32'h1);
        #2 ap_rst_n = 1'b0;
        #1 check_eq("async_done_0a", {31'h0, done_0a}, 32'h0);
        check_eq("async_irq", {31'h0, interrupt}, 32'h0);
        done_0r = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        reg_read_check("post_rst_ctrl", 6'h00, 32'h4);
        reg_read_check("post_rst_ier", 6'h08, 32'h0);

`ifdef SDA_KERNEL_AUTO_RESTART_EN
        reg_write(6'h00, 32'h80);
        reg_read_check("ctrl7_rw", 6'h00, 32'h84);
        reg_write(6'h00, 32'h0);
        go_base = go_count;
        reg_write(6'h00, 32'h81);
        do_go(1);
        do_done(1);
        do_go(1);
        do_done(1);
        do_go(1);
        reg_write(6'h00, 32'h0);
        do_done(1);
        repeat (5) @(negedge ap_clk);
        check_eq("auto_stop", {31'h0, go_0r}, 32'h0);
        check_eq("auto_count", go_count - go_base, 32'h3);
        reg_read_check("auto_ctrl", 6'h00, 32'hE);
`else
        reg_write(6'h00, 32'h80);
        reg_read_check("ctrl7_ro", 6'h00, 32'h4);
        repeat (3) @(negedge ap_clk);
        check_eq("ctrl7_no_go", {31'h0, go_0r}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
